alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one instance of the existing combinational `alu` among NUM_REQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block registers the operands, drives the ALU for one cycle, captures the result and flags, and holds the response until it is accepted.
- It sits between the decode/issue units and the shared ALU in the multi-issue datapath.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 39 +++
 rtl/rr_grant.sv | 32 +++
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and arbiter state type shared by the ALU datapath
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_LUI    = 4'd10;
    localparam logic [3:0] ALU_AUIPC  = 4'd11;
    localparam logic [3:0] ALU_OP_MAX = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with zero and compare flags
module alu
    import alu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_less_than,
    output logic        o_less_than_u
);

    // Compare flags always reflect the operands, independent of the op
    assign o_less_than   = $signed(i_a) < $signed(i_b);
    assign o_less_than_u = i_a < i_b;
    assign o_zero        = (o_result == 32'd0);

    // Result select; codes above ALU_OP_MAX produce zero
    always_comb begin
        o_result = 32'd0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_SLL:   o_result = i_a << i_b[4:0];
            ALU_SLT:   o_result = {31'd0, o_less_than};
            ALU_SLTU:  o_result = {31'd0, o_less_than_u};
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SRL:   o_result = i_a >> i_b[4:0];
            ALU_SRA:   o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            ALU_OR:    o_result = i_a | i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_LUI:   o_result = i_b;
            ALU_AUIPC: o_result = i_a + i_b;
            default:   o_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - round-robin pick starting after the previous winner
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_grant_idx,
    output logic               o_any
);

    // Walk candidates last+1, last+2, ... with wrap and take the first requester
    always_comb begin
        int cand;
        cand        = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(i_last_grant) + k) % NUM_REQ;
            if (!o_any && i_req[cand[IW-1:0]]) begin
                o_any       = 1'b1;
                o_grant_idx = cand[IW-1:0];
            end
        end
        if (o_any) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU among NUM_REQ requesters with round-robin arbitration
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XLEN-1:0] req_a,
    input  logic [NUM_REQ*XLEN-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]    req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]         rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_lt,
    output logic                    rsp_ltu,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    alu_arb_state_t r_state;
    alu_arb_state_t w_next_state;

    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_last_grant;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [3:0]         r_op;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic               r_lt;
    logic               r_ltu;
    logic               r_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_grant_idx;
    logic               w_any;
    logic [XLEN-1:0]    w_alu_result;
    logic               w_alu_zero;
    logic               w_alu_lt;
    logic               w_alu_ltu;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_grant (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    alu u_alu (
        .i_a           (r_a),
        .i_b           (r_b),
        .i_op          (r_op),
        .o_result      (w_alu_result),
        .o_zero        (w_alu_zero),
        .o_less_than   (w_alu_lt),
        .o_less_than_u (w_alu_ltu)
    );

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs; ready is masked while reset is held
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        rsp_valid    = '0;
        case (r_state)
            IDLE: begin
                if (rst_n) begin
                    req_ready = w_grant;
                end
                if (w_any) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture on grant, response capture after the single ALU cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_lt         <= 1'b0;
            r_ltu        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a          <= req_a[w_grant_idx*XLEN +: XLEN];
                        r_b          <= req_b[w_grant_idx*XLEN +: XLEN];
                        r_op         <= req_op[w_grant_idx*4 +: 4];
                        r_owner      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                    end
                end
                EXEC: begin
                    if (r_op > ALU_OP_MAX) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                        r_lt     <= 1'b0;
                        r_ltu    <= 1'b0;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= w_alu_result;
                        r_zero   <= w_alu_zero;
                        r_lt     <= w_alu_lt;
                        r_ltu    <= w_alu_ltu;
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_lt     = r_lt;
    assign rsp_ltu    = r_ltu;
    assign rsp_err    = r_err;
    assign busy       = (r_state != IDLE);

endmodule
